// File: rtl/wr_data_collector_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wr_data_collector_if : accelerator write port plus serialised byte stream |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface wr_data_collector_if #(
  parameter int DATA_W = 21
);
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output wr_req,
    output wr_data,
    output out_ready,
    input  out_byte,
    input  out_valid
  );

  modport slave (
    input  wr_req,
    input  wr_data,
    input  out_ready,
    output out_byte,
    output out_valid
  );
endinterface
`default_nettype wire

// File: rtl/wr_data_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wr_data_collector : captures accelerator words into a FIFO and emits each |
// | word as 3 bytes (LSB first) on a valid/ready stream. Rev 1.0              |
// +--------------------------------------------------------------------------+
module wr_data_collector #(
  parameter int DATA_W = 21,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  wr_data_collector_if.slave   bus,
  input  logic                 acc_done,
  input  logic                 clr,
  output logic [AW:0]          level,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 drained
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic [DATA_W-1:0] r_shreg;
  logic [1:0]        r_idx;
  logic              r_overflow;
  logic              r_done_seen;
  logic              r_drained;

  logic              w_empty;
  logic              w_full;
  logic              w_accept;
  logic              w_last;
  logic              w_pop;
  logic              w_push;
  logic              w_drain;
  logic [23:0]       w_ext;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == (AW+1)'(DEPTH));
  assign w_accept = (r_state == SEND) && bus.out_ready;
  assign w_last   = w_accept && (r_idx == 2'd2);
  // The FIFO head is only taken when the serialiser is free or just finishing.
  assign w_pop    = !w_empty && ((r_state == IDLE) || w_last);
  assign w_push   = bus.wr_req && (!w_full || w_pop);
  assign w_drain  = r_done_seen && w_empty && (r_state == IDLE) && !bus.wr_req;
  assign w_ext    = 24'(r_shreg);

  always_comb begin
    bus.out_byte = w_ext[7:0];
    case (r_idx)
      2'd1:    bus.out_byte = w_ext[15:8];
      2'd2:    bus.out_byte = w_ext[23:16];
      default: bus.out_byte = w_ext[7:0];
    endcase
  end

  assign bus.out_valid = (r_state == SEND);
  assign level         = r_level;
  assign full          = w_full;
  assign empty         = w_empty;
  assign overflow      = r_overflow;
  assign drained       = r_drained;

  // Storage has no reset; validity is tracked entirely by the pointers/level.
  always_ff @(posedge clk) begin
    if (w_push && !clr) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_shreg     <= '0;
      r_idx       <= 2'd0;
      r_overflow  <= 1'b0;
      r_done_seen <= 1'b0;
      r_drained   <= 1'b0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_idx       <= 2'd0;
      r_overflow  <= 1'b0;
      r_done_seen <= 1'b0;
      r_drained   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (bus.wr_req && !w_push) begin
        r_overflow <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shreg <= r_mem[r_rd_ptr];
            r_idx   <= 2'd0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_accept) begin
            if (r_idx != 2'd2) begin
              r_idx <= r_idx + 2'd1;
            end else if (w_pop) begin
              r_shreg <= r_mem[r_rd_ptr];
              r_idx   <= 2'd0;
            end else begin
              r_idx   <= 2'd0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      r_drained <= w_drain;
      if (w_drain) begin
        r_done_seen <= 1'b0;
      end else if (acc_done) begin
        r_done_seen <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wr_data_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wr_data_collector : directed, table-driven bench for wr_data_collector |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_wr_data_collector;

  logic       clk;
  logic       rst;
  logic       acc_done;
  logic       clr;
  logic [3:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       drained;

  int n_cmp;
  int n_bad;

  wr_data_collector_if #(.DATA_W(21)) bus ();

  wr_data_collector #(.DATA_W(21), .DEPTH(8), .AW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .acc_done (acc_done),
    .clr      (clr),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .drained  (drained)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [20:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for a valid byte, samples it and lets it be accepted.
  task automatic get_byte(output logic [7:0] b);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_timeout: got out_valid=0 expected out_valid=1");
      b = 8'h00;
    end else begin
      b = bus.out_byte;
      tick();
    end
  endtask

  task automatic write_word(input logic [20:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_req  = 1'b0;
  endtask

  vec_t vecs [6];
  logic [7:0] b0, b1, b2;
  logic [20:0] wexp;
  logic [7:0] seq [6];
  logic full_seen;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    acc_done = 1'b0;
    clr = 1'b0;
    bus.wr_req = 1'b0;
    bus.wr_data = '0;
    bus.out_ready = 1'b1;

    vecs[0] = '{21'h1ABCDE, 8'hDE, 8'hBC, 8'h1A};
    vecs[1] = '{21'h000001, 8'h01, 8'h00, 8'h00};
    vecs[2] = '{21'h1FFFFF, 8'hFF, 8'hFF, 8'h1F};
    vecs[3] = '{21'h0A5A5A, 8'h5A, 8'h5A, 8'h0A};
    vecs[4] = '{21'h100000, 8'h00, 8'h00, 8'h10};
    vecs[5] = '{21'h012345, 8'h45, 8'h23, 8'h01};

    repeat (3) tick();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_byte", 32'(bus.out_byte), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drained", 32'(drained), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_level", 32'(level), 0);
    rst = 1'b1;
    tick();

    // Single word with acc_done in the same cycle: latency and drained pulse.
    bus.wr_req = 1'b1;
    bus.wr_data = 21'h1ABCDE;
    acc_done = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    acc_done = 1'b0;
    check("lat_valid_e1", 32'(bus.out_valid), 0);
    check("lat_level_e1", 32'(level), 1);
    tick();
    check("lat_valid_e2", 32'(bus.out_valid), 1);
    check("t1_b0", 32'(bus.out_byte), 32'hDE);
    check("t1_drained_early", 32'(drained), 0);
    tick();
    check("t1_b1", 32'(bus.out_byte), 32'hBC);
    tick();
    check("t1_b2", 32'(bus.out_byte), 32'h1A);
    tick();
    check("t1_idle", 32'(bus.out_valid), 0);
    check("t1_drained_e4", 32'(drained), 0);
    tick();
    check("t1_drained_pulse", 32'(drained), 1);
    tick();
    check("t1_drained_low", 32'(drained), 0);

    // Table of single words.
    for (int i = 0; i < 6; i++) begin
      write_word(vecs[i].data);
      get_byte(b0);
      get_byte(b1);
      get_byte(b2);
      check($sformatf("vec%0d_b0", i), 32'(b0), 32'(vecs[i].b0));
      check($sformatf("vec%0d_b1", i), 32'(b1), 32'(vecs[i].b1));
      check($sformatf("vec%0d_b2", i), 32'(b2), 32'(vecs[i].b2));
      check($sformatf("vec%0d_idle", i), 32'(bus.out_valid), 0);
      tick();
    end

    // Back-pressure mid-word holds byte1.
    write_word(21'h1ABCDE);
    tick();
    check("bp_b0", 32'(bus.out_byte), 32'hDE);
    bus.out_ready = 1'b0;
    tick();
    check("bp_b0_held", 32'(bus.out_byte), 32'hDE);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(bus.out_valid), 1);
      check("bp_hold_byte", 32'(bus.out_byte), 32'hBC);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_b2", 32'(bus.out_byte), 32'h1A);
    tick();
    check("bp_done", 32'(bus.out_valid), 0);

    // Overflowing burst of 12 words while the sink stalls.
    bus.out_ready = 1'b0;
    full_seen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      write_word(21'(k * 32'h010203));
      if (full) full_seen = 1'b1;
    end
    check("burst_full_seen", 32'(full_seen), 1);
    check("burst_level", 32'(level), 8);
    check("burst_overflow", 32'(overflow), 1);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      get_byte(b0);
      get_byte(b1);
      get_byte(b2);
      wexp = 21'(k * 32'h010203);
      check($sformatf("burst_word%0d", k), 32'({b2[4:0], b1, b0}), 32'(wexp));
    end
    tick();
    check("burst_drop_idle", 32'(bus.out_valid), 0);
    check("burst_empty", 32'(empty), 1);
    check("burst_overflow_sticky", 32'(overflow), 1);
    clr = 1'b1;
    bus.wr_req = 1'b1;
    bus.wr_data = 21'h0F0F0F;
    tick();
    clr = 1'b0;
    bus.wr_req = 1'b0;
    check("clr_overflow", 32'(overflow), 0);
    check("clr_empty", 32'(empty), 1);
    tick();
    check("clr_word_dropped", 32'(bus.out_valid), 0);

    // Full FIFO pushed on the same edge as the idx2 pop.
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) write_word(21'(k));
    check("fp_level_full", 32'(level), 8);
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.wr_req = 1'b1;
    bus.wr_data = 21'h155555;
    tick();
    bus.wr_req = 1'b0;
    check("fp_level", 32'(level), 8);
    check("fp_overflow", 32'(overflow), 0);
    for (int k = 2; k <= 10; k++) begin
      get_byte(b0);
      get_byte(b1);
      get_byte(b2);
      wexp = (k == 10) ? 21'h155555 : 21'(k);
      check($sformatf("fp_word%0d", k), 32'({b2[4:0], b1, b0}), 32'(wexp));
    end
    tick();

    // Two words back-to-back stream without a gap.
    seq[0] = 8'h33; seq[1] = 8'h22; seq[2] = 8'h11;
    seq[3] = 8'h66; seq[4] = 8'h55; seq[5] = 8'h04;
    write_word(21'h112233);
    write_word(21'h045566);
    for (int i = 0; i < 6; i++) begin
      check("b2b_valid", 32'(bus.out_valid), 1);
      check("b2b_byte", 32'(bus.out_byte), 32'(seq[i]));
      tick();
    end
    check("b2b_end", 32'(bus.out_valid), 0);

    // Reset while byte1 is on the bus aborts immediately.
    write_word(21'h1ABCDE);
    write_word(21'h0ABCDE);
    tick();
    check("rm_b1", 32'(bus.out_byte), 32'hBC);
    check("rm_level_pre", 32'(level), 1);
    #2;
    rst = 1'b0;
    #1;
    check("rm_valid", 32'(bus.out_valid), 0);
    check("rm_level", 32'(level), 0);
    tick();
    rst = 1'b1;
    tick();
    write_word(21'h000001);
    get_byte(b0);
    get_byte(b1);
    get_byte(b2);
    check("rm_new_b0", 32'(b0), 32'h01);
    check("rm_new_b1", 32'(b1), 32'h00);
    check("rm_new_b2", 32'(b2), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
